bin_bcd_seq_ctrl: RTL
=====================

// Module: bin_bcd_seq_ctrl
// PURPOSE
//   Sequential binary-to-BCD conversion controller (shift-and-add-3, "double dabble").
//   Accepts a BIN_W-bit unsigned binary word on a start/busy/done handshake.
//   Iterates one bit per clock and presents DIGITS packed BCD digits.
//   Each output digit is a legal 4-bit BCD code (0-9), ready for the per-digit BCD/7-seg path.
// PARAMETERS
//   BIN_W   8  width of binary input; also the number of conversion cycles
//   DIGITS  3  number of BCD output digits; bcd_out width = 4*DIGITS
// PORTS
//   clk      in   1         system clock; all state updates on rising edge
//   rst      in   1         synchronous, active-high reset
//   start    in   1         conversion request; sampled only in IDLE
//   bin_in   in   BIN_W     unsigned binary operand; captured on the accepted start edge
//   busy     out  1         high while in CONV
//   done     out  1         one-cycle pulse; bcd_out/ovf valid and updated
//   bcd_out  out  4*DIGITS  packed BCD result, digit 0 in [3:0]; holds until next done
//   ovf      out  1         result exceeded 10^DIGITS-1; valid with done, held like bcd_out
// BEHAVIOUR
//   Reset (rst=1 at clk edge): state=IDLE, busy=0, done=0, bcd_out=0, ovf=0,
//     scratch/shift registers=0, cnt=0; rst has priority over every other input.
//   FSM states: IDLE, CONV, DONE (registered outputs, no combinational path in->out).
//   IDLE:
//     - start=1 at edge: load sh<=bin_in, bcd_acc<=0, ovf_acc<=0, cnt<=BIN_W-1; go CONV.
//     - start=0: stay.
//   CONV, each edge:
//     - Adjust: every 4-bit digit of bcd_acc >=5 gets +3; no carry between digits.
//     - Shift: {bcd_acc,sh} shifts left 1; MSB of sh enters bit 0 of bcd_acc.
//     - Overflow: bit shifted out of the top digit MSB sets ovf_acc (sticky).
//     - cnt==0: go DONE, bcd_out<=final bcd_acc, ovf<=ovf_acc|shifted-out bit.
//     - Otherwise: cnt<=cnt-1.
//   DONE: done=1 for exactly one cycle; next edge go IDLE unconditionally.
//   Timing:
//     - Start accepted at edge k: busy=1 in cycles k+1..k+BIN_W.
//     - done=1 in cycle k+BIN_W+1; minimum start-to-start spacing BIN_W+2 cycles.
//   start in CONV or DONE: ignored, not queued. bin_in changes after acceptance: no effect.
//   rst mid-CONV: conversion abandoned, no done pulse, bcd_out/ovf cleared to 0.
//   bin_in=0: bcd_out=0, ovf=0. bin_in=2^BIN_W-1: full-scale result, tested below.
//   On ovf=1, bcd_out holds the low DIGITS digits of the true result (truncated).
//   cnt width = clog2(BIN_W), minimum 1 bit.
//   Digit adders are 4 bits wide: +3 on values 5..9 yields 8..12, no wrap.
// TESTING
//   1 Default params, bin_in=8'd255, start 1 cycle:
//     busy high 8 cycles, done at cycle 9, bcd_out=12'h255, ovf=0.
//   2 bin_in=0 -> bcd_out=12'h000. bin_in=99 -> 12'h099. bin_in=100 -> 12'h100.
//     Each with done exactly once.
//   3 start held high through CONV and DONE:
//     - second conversion accepted only on the first IDLE edge.
//     - done pulses spaced exactly 10 cycles.
//   4 bin_in changed to 8'd7 one cycle after accepted start of 8'd42:
//     result 12'h042.
//   5 rst asserted at 4th CONV cycle:
//     - next cycle busy=0, done=0, bcd_out=0, state IDLE.
//     - new start converts 8'd128 to 12'h128.
//   6 DIGITS=2, bin_in=8'd100 -> bcd_out=8'h00, ovf=1.
//     bin_in=8'd99 -> 8'h99, ovf=0.

Source files
------------

// File: rtl/bin_bcd_seq_ctrl_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master issues start/bin_in. The slave (the converter) returns the
// busy and done status and the packed BCD result with its overflow flag.
interface bin_bcd_seq_ctrl_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, ovf
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, ovf
    );
endinterface

// File: rtl/bin_bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// It processes one binary bit per clock, so a conversion takes BIN_W cycles
// in CONV followed by one DONE cycle. The result and the overflow flag are
// held until the next done pulse.
module bin_bcd_seq_ctrl #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    bin_bcd_seq_ctrl_if.slave    bus
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [BIN_W-1:0]   sh;
    logic [BCD_W-1:0]   bcd_acc;
    logic               ovf_acc;
    logic [CNT_W-1:0]   cnt;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   acc_shift;
    logic               out_bit;
    logic               last_step;

    // Move to the next FSM state on each clock edge; reset returns to IDLE.
    // NOTE: clocked state uses non-blocking (<=), so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Decide the next state. DONE always falls back to IDLE, so a start input held high is not queued.
    // NOTE: defaulting state_next first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CONV;
            CONV:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode the status outputs from the state register only, so no input has a combinational path to them.
    always_comb begin
        bus.busy = (state == CONV);
        bus.done = (state == DONE);
    end

    // Add 3 to every digit that is 5 or more, then shift the next binary MSB into digit 0.
    always_comb begin
        adj = bcd_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_acc[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
        end
        acc_shift = {adj[BCD_W-2:0], sh[BIN_W-1]};
        out_bit   = adj[BCD_W-1];
        last_step = (cnt == CNT_W'(0));
    end

    // Datapath: capture the operand on start, iterate in CONV, and publish the result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh          <= '0;
            bcd_acc     <= '0;
            ovf_acc     <= 1'b0;
            cnt         <= '0;
            bus.bcd_out <= '0;
            bus.ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh      <= bus.bin_in;
                        bcd_acc <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CNT_W'(BIN_W - 1);
                    end
                end
                CONV: begin
                    sh      <= {sh[BIN_W-2:0], 1'b0};
                    bcd_acc <= acc_shift;
                    // Any bit pushed out of the top digit means the value exceeds DIGITS digits.
                    ovf_acc <= ovf_acc | out_bit;
                    if (last_step) begin
                        bus.bcd_out <= acc_shift;
                        bus.ovf     <= ovf_acc | out_bit;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
